// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle issue/capture sequencer in front of a combinational ALU.
// Accepts one operation per request handshake, holds the ALU inputs for the
// operation latency, captures the 35-bit result and offers it on a result handshake.
// Optional feature macro: ALU_SEQ_DIVZERO_TRAP_EN (traps divide-by-zero in IDLE).
module alu_sequencer #(
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned DIV_LAT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_op1,
   input  logic [31:0] req_op2,
   input  logic [5:0]  req_func,
   output logic [31:0] alu_op1,
   output logic [31:0] alu_op2,
   output logic [5:0]  alu_func,
   input  logic [34:0] alu_result,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [34:0] res_data,
   output logic        res_illegal,
   output logic        busy
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned FUNC_W = 6;
   localparam int unsigned RES_W  = 35;
   localparam int unsigned CNT_W  = 4;

   localparam logic [FUNC_W-1:0] FN_ADD = 6'b100000;
   localparam logic [FUNC_W-1:0] FN_SUB = 6'b100010;
   localparam logic [FUNC_W-1:0] FN_MUL = 6'b011000;
   localparam logic [FUNC_W-1:0] FN_DIV = 6'b011010;
   localparam logic [FUNC_W-1:0] FN_AND = 6'b100100;
   localparam logic [FUNC_W-1:0] FN_OR  = 6'b100101;
   localparam logic [FUNC_W-1:0] FN_NOT = 6'b100111;

   // Result word returned for a trapped divide: overflow flag only.
   localparam logic [RES_W-1:0] DIVZERO_RES = {3'b100, 32'h0000_0000};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   alu_op1_q, alu_op1_d;
   logic [DATA_W-1:0]   alu_op2_q, alu_op2_d;
   logic [FUNC_W-1:0]   alu_func_q, alu_func_d;
   logic [RES_W-1:0]    res_data_q, res_data_d;
   logic                res_illegal_q, res_illegal_d;
   logic                req_ready_q, req_ready_d;
   logic                res_valid_q, res_valid_d;
   logic                busy_q, busy_d;

   logic                func_legal_c;
   logic [CNT_W-1:0]    func_lat_c;
   logic                div_trap_c;

   // Decode the requested function: legality and how long the ALU inputs are held.
   always_comb begin
      func_legal_c = 1'b0;
      func_lat_c   = CNT_W'(1);
      unique case (req_func)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOT: begin
            func_legal_c = 1'b1;
         end
         FN_MUL: begin
            func_legal_c = 1'b1;
            func_lat_c   = CNT_W'(MUL_LAT);
         end
         FN_DIV: begin
            func_legal_c = 1'b1;
            func_lat_c   = CNT_W'(DIV_LAT);
         end
         default: begin
            func_legal_c = 1'b0;
         end
      endcase
   end

`ifdef ALU_SEQ_DIVZERO_TRAP_EN
   // Divide by zero is answered locally and never reaches the ALU.
   assign div_trap_c = (req_func == FN_DIV) && (req_op2 == '0);
`else
   // Divide by zero is issued to the ALU like any other divide.
   assign div_trap_c = 1'b0;
`endif

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      alu_op1_d     = alu_op1_q;
      alu_op2_d     = alu_op2_q;
      alu_func_d    = alu_func_q;
      res_data_d    = res_data_q;
      res_illegal_d = res_illegal_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (div_trap_c) begin
                  res_data_d    = DIVZERO_RES;
                  res_illegal_d = 1'b0;
                  state_d       = ST_DONE;
               end else if (!func_legal_c) begin
                  res_data_d    = '0;
                  res_illegal_d = 1'b1;
                  state_d       = ST_DONE;
               end else begin
                  alu_op1_d  = req_op1;
                  alu_op2_d  = req_op2;
                  alu_func_d = req_func;
                  cnt_d      = func_lat_c;
                  state_d    = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               res_data_d    = alu_result;
               res_illegal_d = 1'b0;
               state_d       = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      req_ready_d = (state_d == ST_IDLE);
      res_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   // State, counter, ALU input and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         alu_op1_q     <= '0;
         alu_op2_q     <= '0;
         alu_func_q    <= '0;
         res_data_q    <= '0;
         res_illegal_q <= 1'b0;
         req_ready_q   <= 1'b1;
         res_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         alu_op1_q     <= alu_op1_d;
         alu_op2_q     <= alu_op2_d;
         alu_func_q    <= alu_func_d;
         res_data_q    <= res_data_d;
         res_illegal_q <= res_illegal_d;
         req_ready_q   <= req_ready_d;
         res_valid_q   <= res_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign res_valid   = res_valid_q;
   assign busy        = busy_q;
   assign res_data    = res_data_q;
   assign res_illegal = res_illegal_q;
   assign alu_op1     = alu_op1_q;
   assign alu_op2     = alu_op2_q;
   assign alu_func    = alu_func_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU and reference model.
module tb_alu_sequencer;

   localparam int unsigned MUL_LAT = 4;
   localparam int unsigned DIV_LAT = 8;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_op1;
   logic [31:0] req_op2;
   logic [5:0]  req_func;
   logic [31:0] alu_op1;
   logic [31:0] alu_op2;
   logic [5:0]  alu_func;
   logic [34:0] alu_result;
   logic        res_valid;
   logic        res_ready;
   logic [34:0] res_data;
   logic        res_illegal;
   logic        busy;

   int total = 0;
   int bad   = 0;

   // Values the ALU inputs should currently hold (last issued legal op).
   logic [31:0] exp_op1;
   logic [31:0] exp_op2;
   logic [5:0]  exp_func;

   alu_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op1(req_op1), .req_op2(req_op2), .req_func(req_func),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_func(alu_func),
      .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_illegal(res_illegal), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: {overflow, equals, above, data}.
   function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f);
      logic [31:0] d;
      logic        ovf;
      longint      p;
      d   = '0;
      ovf = 1'b0;
      p   = 0;
      case (f)
         6'b100000: begin d = a + b; ovf = (a[31] == b[31]) && (d[31] != a[31]); end
         6'b100010: begin d = a - b; ovf = (a[31] != b[31]) && (d[31] != a[31]); end
         6'b011000: begin
            p   = longint'($signed(a)) * longint'($signed(b));
            d   = p[31:0];
            ovf = (p != longint'($signed(d)));
         end
         6'b011010: begin
            if (b == 32'h0) begin
               d = 32'hFFFF_FFFF; ovf = 1'b1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               d = a; ovf = 1'b1;
            end else begin
               d = 32'($signed(a) / $signed(b));
            end
         end
         6'b100100: d = a & b;
         6'b100101: d = a | b;
         6'b100111: d = ~a;
         default:   d = '0;
      endcase
      return {ovf, (a == b), ($signed(a) > $signed(b)), d};
   endfunction

   assign alu_result = alu_fn(alu_op1, alu_op2, alu_func);

   function automatic bit is_legal(input logic [5:0] f);
      logic [5:0] codes [7];
      codes = '{6'b100000, 6'b100010, 6'b011000, 6'b011010, 6'b100100, 6'b100101, 6'b100111};
      foreach (codes[i]) if (codes[i] == f) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit is_trap(input logic [5:0] f, input logic [31:0] b);
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
      return (f == 6'b011010) && (b == 32'h0);
`else
      return 1'b0 && (f == b[5:0]);
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "/req_ready"},   64'(req_ready),   64'(1));
      chk({tag, "/res_valid"},   64'(res_valid),   64'(0));
      chk({tag, "/busy"},        64'(busy),        64'(0));
      chk({tag, "/res_data"},    64'(res_data),    64'(0));
      chk({tag, "/res_illegal"}, 64'(res_illegal), 64'(0));
      chk({tag, "/alu_op1"},     64'(alu_op1),     64'(0));
      chk({tag, "/alu_op2"},     64'(alu_op2),     64'(0));
      chk({tag, "/alu_func"},    64'(alu_func),    64'(0));
   endtask

   // Issue one op, measure latency, check result, apply 'hold' cycles of backpressure.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] f, input int hold);
      logic [34:0] exp_res;
      logic        exp_ill;
      int          exp_lat;
      int          k;
      if (is_trap(f, b)) begin
         exp_res = {3'b100, 32'h0}; exp_ill = 1'b0; exp_lat = 1;
      end else if (!is_legal(f)) begin
         exp_res = '0; exp_ill = 1'b1; exp_lat = 1;
      end else begin
         exp_res  = alu_fn(a, b, f);
         exp_ill  = 1'b0;
         exp_lat  = (f == 6'b011000) ? int'(MUL_LAT) + 1 :
                    (f == 6'b011010) ? int'(DIV_LAT) + 1 : 2;
         exp_op1  = a;
         exp_op2  = b;
         exp_func = f;
      end

      @(negedge clk);
      chk({tag, "/idle_ready"}, 64'(req_ready), 64'(1));
      req_valid = 1'b1; req_op1 = a; req_op2 = b; req_func = f;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_op1 = $urandom; req_op2 = $urandom; req_func = 6'($urandom);
      k = 0;
      while (res_valid !== 1'b1 && k < 64) begin
         chk({tag, "/exec_op1"},  64'(alu_op1),  64'(exp_op1));
         chk({tag, "/exec_func"}, 64'(alu_func), 64'(exp_func));
         chk({tag, "/exec_busy"}, 64'(busy),     64'(1));
         @(negedge clk);
         k++;
      end
      chk({tag, "/res_valid"},   64'(res_valid),   64'(1));
      chk({tag, "/latency"},     64'(k + 1),       64'(exp_lat));
      chk({tag, "/res_data"},    64'(res_data),    64'(exp_res));
      chk({tag, "/res_illegal"}, 64'(res_illegal), 64'(exp_ill));
      chk({tag, "/done_ready"},  64'(req_ready),   64'(0));
      chk({tag, "/alu_op2"},     64'(alu_op2),     64'(exp_op2));
      chk({tag, "/alu_func"},    64'(alu_func),    64'(exp_func));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, "/hold_valid"}, 64'(res_valid), 64'(1));
         chk({tag, "/hold_data"},  64'(res_data),  64'(exp_res));
         chk({tag, "/hold_ready"}, 64'(req_ready), 64'(0));
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({tag, "/ret_valid"}, 64'(res_valid), 64'(0));
      chk({tag, "/ret_ready"}, 64'(req_ready), 64'(1));
      chk({tag, "/ret_busy"},  64'(busy),      64'(0));
   endtask

   initial begin
      logic [5:0] codes [8];
      logic [5:0] f;
      codes = '{6'b100000, 6'b100010, 6'b011000, 6'b011010,
                6'b100100, 6'b100101, 6'b100111, 6'b000001};
      rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
      req_op1 = '0; req_op2 = '0; req_func = '0;
      exp_op1 = '0; exp_op2 = '0; exp_func = '0;
      #12;
      chk_reset_vals("por");
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add", 32'd5, 32'd7, 6'b100000, 0);
      chk("add/data12", 64'(res_data[31:0]), 64'(12));
      run_op("mul", 32'd3, 32'd4, 6'b011000, 0);
      chk("mul/data12", 64'(res_data[31:0]), 64'(12));
      run_op("div", 32'd100, 32'd7, 6'b011010, 0);
      chk("div/data14", 64'(res_data[31:0]), 64'(14));
      run_op("sub_bp", 32'd9, 32'd9, 6'b100010, 6);
      chk("sub_bp/equals", 64'(res_data[33]), 64'(1));
      run_op("illegal", 32'd1, 32'd2, 6'b000001, 2);
      chk("illegal/alu_func", 64'(alu_func), 64'(6'b100010));
      run_op("divzero", 32'd100, 32'd0, 6'b011010, 1);

      // Reset in the middle of a multiply drops it.
      @(negedge clk);
      req_valid = 1'b1; req_op1 = 32'd3; req_op2 = 32'd4; req_func = 6'b011000;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      exp_op1 = '0; exp_op2 = '0; exp_func = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("midrst/no_result", 64'(res_valid), 64'(0));
      end
      chk("midrst/ready", 64'(req_ready), 64'(1));

      for (int i = 0; i < 40; i++) begin
         f = codes[$urandom_range(0, 7)];
         if ($urandom_range(0, 9) == 0) f = 6'($urandom);
         run_op("rand", $urandom, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom, f,
                int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
